multi_channel_framer: RTL and testbench
=======================================

# multi_channel_framer

Parametrised successor to the single-stream RSSI framer. It collects the latest sample from NUM_CH independent producers, such as per-antenna RSSI datapaths, and optionally decimates complete sample sets. It then emits each selected set as a checksummed byte frame into the UART TX FIFO, honouring FIFO backpressure. It sits between the datapath outputs and `UartTx` in the core clock domain.

## Interface
- NUM_CH, 3: number of input channels (1..8).
- DW, 16: bits per channel sample (1..32). NB = ceil(DW/8) payload bytes per channel.
- DECIM, 1: emit one frame per DECIM complete sample sets (1..256).
- SYNC0, 8'hA5: first sync byte.
- SYNC1, 8'h5A: second sync byte.
- clk  in  1  core clock; all logic is single-domain on this clock.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  frame generation enable.
- data_i  in  NUM_CH*DW  channel samples; channel k occupies bits [k*DW +: DW].
- valid_i  in  NUM_CH  per-channel sample strobe; a 1-cycle pulse per sample.
- fifo_full_i  in  1  UART FIFO full flag.
- uart_data  out  8  frame byte to the FIFO.
- wr_en_o  out  1  FIFO write strobe.
- busy_o  out  1  high while a frame is being emitted.
- overrun_cnt_o  out  8  saturating count of dropped samples.

## Operation
- Per-channel hold register `hold[k]` (DW bits) and `fresh[k]` flag.
  - valid_i[k] loads hold[k] and sets fresh[k].
  - Capture is active in every state.
- Overrun: valid_i[k] while fresh[k]=1, and fresh[k] is not being cleared in the same cycle.
  - The new value overwrites the old one.
  - overrun_cnt_o increments and saturates at 255.
- Set complete: all fresh bits = 1, evaluated on registered flags.
- States: IDLE, SEND.
- IDLE with set complete and en_i=1:
  - Clear all fresh bits.
  - Increment the decimation counter `dcnt`.
  - If dcnt == DECIM-1:
    - Snapshot all hold registers into the frame buffer and latch `seq`.
    - Set dcnt = 0, byte index = 0, go to SEND.
  - Otherwise stay in IDLE.
- en_i=0 in IDLE: fresh bits are cleared every cycle; no frame starts; dcnt holds.
  - en_i=0 during SEND does not abort the current frame.
- Simultaneous snapshot and valid_i[k]:
  - The snapshot takes the old hold[k].
  - hold[k] takes the new value and fresh[k] stays 1.
  - This is not counted as an overrun.
- Frame byte order, length L = 5 + NUM_CH*NB:
  1. SYNC0
  2. SYNC1
  3. SEQ
  4. LEN = NUM_CH*NB
  5. Payload: channel 0 first, LS byte first within each channel, zero-extended to NB bytes.
  6. CHK
- CHK = (SEQ + LEN + sum of all payload bytes) mod 256. Sync bytes are excluded from CHK.
- seq: 8 bits, increments by 1 after the CHK byte is written, wraps 255 → 0.
- SEND:
  - wr_en_o = !fifo_full_i, combinational. It is the only combinational output.
  - uart_data = byte[idx], muxed from registers.
  - idx advances on each edge where wr_en_o=1.
  - After the CHK byte is written, go to IDLE.
- busy_o = (state == SEND).
- Reset: state IDLE, all fresh = 0, hold = 0, dcnt = 0, seq = 0, idx = 0, overrun_cnt_o = 0, uart_data = 0, wr_en_o = 0, busy_o = 0.
- Reset mid-frame aborts immediately. The partial frame is not completed; the host resyncs on SYNC0/SYNC1.

## Timing
- Last valid_i of a set in cycle c:
  - Cycle c+1: IDLE sees the set complete; snapshot taken at end of c+1.
  - Cycle c+2: first SYNC0 write, if FIFO not full.
- No backpressure: bytes are written in cycles c+2 .. c+1+L, one per cycle, contiguous.
- fifo_full_i=1 in a SEND cycle: no write, and idx and uart_data hold. Each full cycle stretches the frame by exactly one cycle.
- Back-to-back frames: at least one IDLE cycle between the CHK write and the next SYNC0.
- A set completing during SEND is held; it starts in the first IDLE cycle after the frame ends.
- Skipped (decimated) sets consume one IDLE cycle each and produce no writes.

## Test plan
- Basic frame, defaults, channels = 0x1234, 0x0056, 0xFFFF:
  - Expect wr_en_o bytes A5 5A 00 06 34 12 56 00 FF FF A0, on 11 consecutive cycles starting 2 cycles after the last valid.
- Backpressure: hold fifo_full_i=1 for 3 cycles while byte index 5 is pending.
  - Expect no writes during those cycles, the identical byte stream, and the frame 3 cycles longer.
- Overrun and wrap:
  - Pulse channel 0 valid twice (0x0001, then 0x0002) before channels 1 and 2.
  - Expect overrun_cnt_o = 1 and payload bytes 02 00.
  - Run 257 frames; expect SEQ values 0..255, then 0.
- DECIM=4: feed 8 complete sets with channel 0 values 1..8.
  - Expect exactly 2 frames, SEQ 0 and 1, carrying values 4 and 8.
- DW=12, NUM_CH=1, sample 0xABC:
  - Expect frame A5 5A 00 02 BC 0A C8.
- Reset mid-frame: assert rst after byte 4 is written, then run a new set.
  - Expect writes to stop the next cycle and all outputs at reset values.
  - Expect the next frame to start with SEQ 00.

Source files
------------

// File: rtl/multi_channel_framer.sv
// rtl/multi_channel_framer.sv - multi-channel sample collector emitting checksummed byte frames
module multi_channel_framer #(
    parameter int         NUM_CH = 3,
    parameter int         DW     = 16,
    parameter int         DECIM  = 1,
    parameter logic [7:0] SYNC0  = 8'hA5,
    parameter logic [7:0] SYNC1  = 8'h5A
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [NUM_CH*DW-1:0]   data_i,
    input  logic [NUM_CH-1:0]      valid_i,
    input  logic                   fifo_full_i,
    output logic [7:0]             uart_data,
    output logic                   wr_en_o,
    output logic                   busy_o,
    output logic [7:0]             overrun_cnt_o
);

    localparam int              NB        = (DW + 7) / 8;
    localparam int              NPB       = NUM_CH * NB;
    localparam int              L         = 5 + NPB;
    localparam int              IW        = 6;
    localparam int              DCW       = 9;
    localparam logic [7:0]      LEN       = 8'(NPB);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(L - 1);
    localparam logic [DCW-1:0]  DCNT_LAST = DCW'(DECIM - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             r_state;
    logic [DW-1:0]      r_hold [NUM_CH];
    logic [NUM_CH-1:0]  r_fresh;
    logic [DCW-1:0]     r_dcnt;
    logic [7:0]         r_seq;
    logic [IW-1:0]      r_idx;
    logic [7:0]         r_pay [NPB];
    logic [7:0]         r_chk;
    logic [7:0]         r_uart_data;
    logic [7:0]         r_ovr;
    logic               r_busy;

    logic               w_complete;
    logic               w_clr;
    logic               w_fire;
    logic               w_snap;
    logic               w_wr;
    logic [IW-1:0]      w_nidx;
    logic [7:0]         w_next_byte;
    logic [NB*8-1:0]    w_ext;
    logic [7:0]         w_snap_bytes [NPB];
    logic [7:0]         w_chk;
    logic [NUM_CH-1:0]  w_ovr_hits;
    logic [3:0]         w_ovr_n;
    logic [8:0]         w_ovr_sum;
    logic [7:0]         w_ovr_next;

    // Set detection works on registered fresh flags; flags are dropped whenever IDLE consumes or discards a set
    assign w_complete = &r_fresh;
    assign w_clr      = (r_state == S_IDLE) && (!en_i || w_complete);
    assign w_fire     = (r_state == S_IDLE) && en_i && w_complete;
    assign w_snap     = w_fire && (r_dcnt == DCNT_LAST);
    assign w_wr       = (r_state == S_SEND) && !fifo_full_i;
    assign w_nidx     = r_idx + IW'(1);

    assign uart_data     = r_uart_data;
    assign wr_en_o       = w_wr;
    assign busy_o        = r_busy;
    assign overrun_cnt_o = r_ovr;

    // Split the hold registers into zero-extended payload bytes and sum them with SEQ and LEN for the checksum
    always_comb begin
        w_ext = '0;
        w_chk = r_seq + LEN;
        for (int k = 0; k < NUM_CH; k++) begin
            w_ext = '0;
            w_ext[DW-1:0] = r_hold[k];
            for (int b = 0; b < NB; b++) begin
                w_snap_bytes[k*NB+b] = w_ext[8*b +: 8];
                w_chk = w_chk + w_ext[8*b +: 8];
            end
        end
    end

    // Byte that follows the one currently presented; the CHK byte is the fallback for the last index
    always_comb begin
        w_next_byte = r_chk;
        for (int i = 0; i < NPB; i++) begin
            if (w_nidx == IW'(i + 4)) begin
                w_next_byte = r_pay[i];
            end
        end
        if (w_nidx == IW'(1)) begin
            w_next_byte = SYNC1;
        end else if (w_nidx == IW'(2)) begin
            w_next_byte = r_seq;
        end else if (w_nidx == IW'(3)) begin
            w_next_byte = LEN;
        end
    end

    // A sample is dropped when it lands on a still-fresh channel that is not being consumed this cycle
    always_comb begin
        w_ovr_hits = valid_i & r_fresh & ~{NUM_CH{w_clr}};
        w_ovr_n    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_ovr_n = w_ovr_n + 4'(w_ovr_hits[k]);
        end
        w_ovr_sum  = {1'b0, r_ovr} + 9'(w_ovr_n);
        w_ovr_next = (w_ovr_sum > 9'd255) ? 8'hFF : w_ovr_sum[7:0];
    end

    // Capture, decimation and frame emission state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fresh     <= '0;
            r_dcnt      <= '0;
            r_seq       <= '0;
            r_idx       <= '0;
            r_chk       <= '0;
            r_uart_data <= '0;
            r_ovr       <= '0;
            r_busy      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_hold[k] <= '0;
            end
            for (int i = 0; i < NPB; i++) begin
                r_pay[i] <= '0;
            end
        end else begin
            // A new sample always lands, even on the snapshot edge; the snapshot sees the old value
            for (int k = 0; k < NUM_CH; k++) begin
                if (valid_i[k]) begin
                    r_hold[k] <= data_i[k*DW +: DW];
                end
            end
            r_fresh <= (w_clr ? '0 : r_fresh) | valid_i;
            r_ovr   <= w_ovr_next;

            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        if (w_snap) begin
                            for (int i = 0; i < NPB; i++) begin
                                r_pay[i] <= w_snap_bytes[i];
                            end
                            r_chk       <= w_chk;
                            r_dcnt      <= '0;
                            r_idx       <= '0;
                            r_uart_data <= SYNC0;
                            r_busy      <= 1'b1;
                            r_state     <= S_SEND;
                        end else begin
                            r_dcnt <= r_dcnt + DCW'(1);
                        end
                    end
                end
                S_SEND: begin
                    if (w_wr) begin
                        if (r_idx == LAST_IDX) begin
                            r_seq       <= r_seq + 8'd1;
                            r_idx       <= '0;
                            r_uart_data <= '0;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx       <= w_nidx;
                            r_uart_data <= w_next_byte;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_framer.sv
// tb/tb_multi_channel_framer.sv - self-checking bench for multi_channel_framer
module tb_multi_channel_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance
    logic        en_a, full_a, wr_a, busy_a;
    logic [47:0] data_a;
    logic [2:0]  valid_a;
    logic [7:0]  ud_a, ovr_a;
    // DECIM=4 instance
    logic        en_b, full_b, wr_b, busy_b;
    logic [47:0] data_b;
    logic [2:0]  valid_b;
    logic [7:0]  ud_b, ovr_b;
    // DW=12, NUM_CH=1 instance
    logic        en_c, full_c, wr_c, busy_c;
    logic [11:0] data_c;
    logic [0:0]  valid_c;
    logic [7:0]  ud_c, ovr_c;

    multi_channel_framer dut_a (
        .clk(clk), .rst(rst), .en_i(en_a), .data_i(data_a), .valid_i(valid_a),
        .fifo_full_i(full_a), .uart_data(ud_a), .wr_en_o(wr_a), .busy_o(busy_a),
        .overrun_cnt_o(ovr_a)
    );

    multi_channel_framer #(.DECIM(4)) dut_b (
        .clk(clk), .rst(rst), .en_i(en_b), .data_i(data_b), .valid_i(valid_b),
        .fifo_full_i(full_b), .uart_data(ud_b), .wr_en_o(wr_b), .busy_o(busy_b),
        .overrun_cnt_o(ovr_b)
    );

    multi_channel_framer #(.NUM_CH(1), .DW(12)) dut_c (
        .clk(clk), .rst(rst), .en_i(en_c), .data_i(data_c), .valid_i(valid_c),
        .fifo_full_i(full_c), .uart_data(ud_c), .wr_en_o(wr_c), .busy_o(busy_c),
        .overrun_cnt_o(ovr_c)
    );

    // write monitors: every FIFO write with the cycle it happened in
    logic [7:0] qa[$], qb[$], qc[$];
    int         qa_c[$], qb_c[$], qc_c[$];
    always @(negedge clk) if (wr_a) begin qa.push_back(ud_a); qa_c.push_back(cyc); end
    always @(negedge clk) if (wr_b) begin qb.push_back(ud_b); qb_c.push_back(cyc); end
    always @(negedge clk) if (wr_c) begin qc.push_back(ud_c); qc_c.push_back(cyc); end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference frame model
    logic [31:0] vals [8];
    logic [7:0]  exp_fr [64];
    int          exp_len;
    logic [7:0]  got [64];
    int          got_c [64];

    task automatic build_frame(input logic [7:0] seq, input int nch, input int dw);
        int          nb;
        logic [31:0] m;
        logic [7:0]  s;
        nb = (dw + 7) / 8;
        exp_fr[0] = 8'hA5;
        exp_fr[1] = 8'h5A;
        exp_fr[2] = seq;
        exp_fr[3] = 8'(nch * nb);
        exp_len = 4;
        for (int k = 0; k < nch; k++) begin
            m = (dw == 32) ? vals[k] : (vals[k] & ((32'd1 << dw) - 32'd1));
            for (int b = 0; b < nb; b++) begin
                exp_fr[exp_len] = 8'(m >> (8 * b));
                exp_len = exp_len + 1;
            end
        end
        s = 8'd0;
        for (int i = 2; i < exp_len; i++) s = s + exp_fr[i];
        exp_fr[exp_len] = s;
        exp_len = exp_len + 1;
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic pop1(input int which, output logic [7:0] b, output int c);
        case (which)
            0:       begin b = qa.pop_front(); c = qa_c.pop_front(); end
            1:       begin b = qb.pop_front(); c = qb_c.pop_front(); end
            default: begin b = qc.pop_front(); c = qc_c.pop_front(); end
        endcase
    endtask

    task automatic flush(input int which);
        case (which)
            0:       begin qa.delete(); qa_c.delete(); end
            1:       begin qb.delete(); qb_c.delete(); end
            default: begin qc.delete(); qc_c.delete(); end
        endcase
    endtask

    // compare one captured frame against exp_fr; t0 < 0 skips the timing checks
    task automatic pop_check(input int which, input string nm, input int t0, input int stretch);
        int n;
        n = qsize(which);
        chk($sformatf("%s length", nm), 64'(n), 64'(exp_len));
        for (int i = 0; i < exp_len; i++) begin
            if (i < n) begin
                pop1(which, got[i], got_c[i]);
                chk($sformatf("%s byte %0d", nm, i), 64'(got[i]), 64'(exp_fr[i]));
            end
        end
        if (t0 >= 0 && n >= exp_len) begin
            chk($sformatf("%s first cycle", nm), 64'(got_c[0] - t0), 64'd0);
            chk($sformatf("%s last cycle", nm), 64'(got_c[exp_len-1] - t0), 64'(exp_len - 1 + stretch));
        end
        flush(which);
    endtask

    // wait (bounded) for n captured bytes, optionally toggling backpressure on the default instance
    task automatic wait_bytes(input int which, input int n, input int budget, input bit rand_bp, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (qsize(which) >= n) begin
                ok = 1'b1;
                break;
            end
            if (rand_bp) full_a = (($urandom % 4) == 0);
            tick();
        end
        full_a = 1'b0;
    endtask

    task automatic apply_a();
        data_a  = {vals[2][15:0], vals[1][15:0], vals[0][15:0]};
        valid_a = 3'b111;
        tick();
        valid_a = 3'b000;
    endtask

    typedef struct {
        logic [15:0] ch  [3];
        logic [7:0]  exp [11];
    } vec_t;
    vec_t tbl [4];

    logic [7:0] seq_a;
    int         ovr_exp;
    int         c0;
    bit         ok;
    logic [2:0] pend, r_sel, o_sel;
    int         guard;

    initial begin
        tbl[0].ch  = '{16'h1234, 16'h0056, 16'hFFFF};
        tbl[0].exp = '{8'hA5, 8'h5A, 8'h00, 8'h06, 8'h34, 8'h12, 8'h56, 8'h00, 8'hFF, 8'hFF, 8'hA0};
        tbl[1].ch  = '{16'h0000, 16'h0000, 16'h0000};
        tbl[1].exp = '{8'hA5, 8'h5A, 8'h01, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
        tbl[2].ch  = '{16'h0102, 16'h0304, 16'h0506};
        tbl[2].exp = '{8'hA5, 8'h5A, 8'h02, 8'h06, 8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'h1D};
        tbl[3].ch  = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[3].exp = '{8'hA5, 8'h5A, 8'h03, 8'h06, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};
        for (int i = 0; i < 8; i++) vals[i] = '0;

        rst = 1'b1;
        en_a = 1'b1; full_a = 1'b0; data_a = '0; valid_a = '0;
        en_b = 1'b1; full_b = 1'b0; data_b = '0; valid_b = '0;
        en_c = 1'b1; full_c = 1'b0; data_c = '0; valid_c = '0;
        tick(); tick();
        chk("reset wr_en", 64'(wr_a), 64'd0);
        chk("reset uart_data", 64'(ud_a), 64'd0);
        chk("reset busy", 64'(busy_a), 64'd0);
        chk("reset overrun", 64'(ovr_a), 64'd0);
        rst = 1'b0;
        tick();

        // DW=12 single channel
        c0 = cyc;
        data_c = 12'hABC; valid_c = 1'b1;
        tick();
        valid_c = 1'b0;
        wait_bytes(2, 7, 40, 1'b0, ok);
        chk("dw12 timeout", 64'(ok), 64'd1);
        tick(); tick();
        exp_fr[0] = 8'hA5; exp_fr[1] = 8'h5A; exp_fr[2] = 8'h00; exp_fr[3] = 8'h02;
        exp_fr[4] = 8'hBC; exp_fr[5] = 8'h0A; exp_fr[6] = 8'hC8; exp_len = 7;
        pop_check(2, "dw12", c0 + 2, 0);

        // DECIM=4: eight sets, only the 4th and 8th are framed
        for (int s = 1; s <= 8; s++) begin
            data_b  = {16'(16'h0200 + s), 16'(16'h0100 + s), 16'(s)};
            valid_b = 3'b111;
            tick();
            valid_b = 3'b000;
            for (int i = 0; i < 20; i++) tick();
        end
        chk("decim write count", 64'(qsize(1)), 64'd22);
        vals[0] = 32'd4; vals[1] = 32'h104; vals[2] = 32'h204;
        build_frame(8'd0, 3, 16);
        pop1(1, got[0], got_c[0]);
        for (int i = 1; i < 11 && qsize(1) > 0; i++) pop1(1, got[i], got_c[i]);
        for (int i = 0; i < 11; i++) chk($sformatf("decim f0 byte %0d", i), 64'(got[i]), 64'(exp_fr[i]));
        vals[0] = 32'd8; vals[1] = 32'h108; vals[2] = 32'h208;
        build_frame(8'd1, 3, 16);
        pop_check(1, "decim f1", -1, 0);

        // table-driven basic frames on the default instance
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 3; k++) vals[k] = 32'(tbl[t].ch[k]);
            c0 = cyc;
            apply_a();
            wait_bytes(0, 11, 40, 1'b0, ok);
            chk($sformatf("vec%0d timeout", t), 64'(ok), 64'd1);
            tick(); tick();
            for (int i = 0; i < 11; i++) exp_fr[i] = tbl[t].exp[i];
            exp_len = 11;
            pop_check(0, $sformatf("vec%0d", t), c0 + 2, 0);
        end
        seq_a = 8'd4;
        ovr_exp = 0;

        // backpressure for 3 cycles while byte index 5 is pending
        vals[0] = 32'h1234; vals[1] = 32'h0056; vals[2] = 32'hFFFF;
        build_frame(seq_a, 3, 16);
        c0 = cyc;
        apply_a();
        while (cyc < c0 + 7) tick();
        full_a = 1'b1;
        tick(); tick(); tick();
        full_a = 1'b0;
        wait_bytes(0, 11, 40, 1'b0, ok);
        chk("bp timeout", 64'(ok), 64'd1);
        tick(); tick();
        pop_check(0, "bp", c0 + 2, 3);
        chk("bp byte4 cycle", 64'(got_c[4] - c0), 64'd6);
        chk("bp byte5 cycle", 64'(got_c[5] - c0), 64'd10);
        seq_a = seq_a + 8'd1;

        // overrun on channel 0 before the set completes
        data_a = {16'h0004, 16'h0003, 16'h0001}; valid_a = 3'b001; tick();
        data_a = {16'h0004, 16'h0003, 16'h0002}; valid_a = 3'b001; tick();
        valid_a = 3'b110; tick();
        valid_a = 3'b000;
        vals[0] = 32'd2; vals[1] = 32'd3; vals[2] = 32'd4;
        build_frame(seq_a, 3, 16);
        wait_bytes(0, 11, 40, 1'b0, ok);
        chk("ovr timeout", 64'(ok), 64'd1);
        tick(); tick();
        pop_check(0, "ovr", -1, 0);
        chk("ovr count", 64'(ovr_a), 64'd1);
        ovr_exp = 1;
        seq_a = seq_a + 8'd1;

        // disabled: a complete set is discarded
        en_a = 1'b0;
        vals[0] = 32'd9; vals[1] = 32'd9; vals[2] = 32'd9;
        apply_a();
        tick(); tick(); tick();
        en_a = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("disabled writes", 64'(qsize(0)), 64'd0);
        chk("disabled busy", 64'(busy_a), 64'd0);

        // random sets, random arrival order, overruns and backpressure; 251 frames take SEQ through 255 back to 0
        for (int f = 0; f < 251; f++) begin
            pend = 3'b111;
            guard = 0;
            while (pend != 3'b000) begin
                r_sel = 3'($urandom) & pend;
                if (guard > 20) r_sel = pend;
                o_sel = 3'b000;
                if (($urandom % 6) == 0) o_sel = 3'($urandom) & ~pend;
                for (int k = 0; k < 3; k++) begin
                    if (r_sel[k] || o_sel[k]) vals[k] = $urandom & 32'hFFFF;
                    if (o_sel[k]) ovr_exp = (ovr_exp < 255) ? ovr_exp + 1 : 255;
                end
                data_a  = {vals[2][15:0], vals[1][15:0], vals[0][15:0]};
                valid_a = r_sel | o_sel;
                tick();
                pend  = pend & ~r_sel;
                guard = guard + 1;
            end
            valid_a = 3'b000;
            build_frame(seq_a, 3, 16);
            wait_bytes(0, 11, 200, 1'b1, ok);
            chk($sformatf("rand%0d timeout", f), 64'(ok), 64'd1);
            tick(); tick();
            pop_check(0, $sformatf("rand%0d", f), -1, 0);
            chk($sformatf("rand%0d overrun", f), 64'(ovr_a), 64'(ovr_exp));
            seq_a = seq_a + 8'd1;
        end
        chk("seq wrap", 64'(got[2]), 64'd0);

        // reset in the middle of a frame
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        c0 = cyc;
        apply_a();
        while (cyc < c0 + 7) tick();
        rst = 1'b1;
        tick();
        chk("midrst wr_en", 64'(wr_a), 64'd0);
        chk("midrst uart_data", 64'(ud_a), 64'd0);
        chk("midrst busy", 64'(busy_a), 64'd0);
        chk("midrst overrun", 64'(ovr_a), 64'd0);
        tick();
        chk("midrst partial writes", 64'(qsize(0)), 64'd6);
        flush(0);
        rst = 1'b0;
        tick();
        vals[0] = 32'hBEEF; vals[1] = 32'h0102; vals[2] = 32'h7F80;
        build_frame(8'd0, 3, 16);
        c0 = cyc;
        apply_a();
        wait_bytes(0, 11, 40, 1'b0, ok);
        chk("postrst timeout", 64'(ok), 64'd1);
        tick(); tick();
        pop_check(0, "postrst", c0 + 2, 0);
        chk("postrst seq", 64'(got[2]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
